// File: rtl/tx_rx_switch_ctrl.sv
// T/R antenna-switch and receiver-blanking controller driven by the TX-on detector.
// Measures per-frame RF airtime and BB-end tail, and aborts runaway transmissions.
module tx_rx_switch_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TAIL_W  = 12,
  parameter int unsigned GUARD_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_bb_is_ongoing,
  input  logic               tx_rf_is_ongoing,
  input  logic               pulse_tx_bb_end_almost,
  input  logic [GUARD_W-1:0] post_guard_top,
  input  logic [CNT_W-1:0]   max_tx_top,
  input  logic               wd_err_clr,
  output logic               rx_blank,
  output logic               tx_ant_sel,
  output logic [CNT_W-1:0]   tx_airtime,
  output logic [TAIL_W-1:0]  tail_cnt,
  output logic               meas_valid,
  output logic               wd_err,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StTxBb  = 3'd1,
    StTxRf  = 3'd2,
    StGuard = 3'd3,
    StAbort = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]   wd_q, wd_d;
  logic [CNT_W-1:0]   air_q, air_d;
  logic [TAIL_W-1:0]  tail_q, tail_d;
  logic               armed_q, armed_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic [CNT_W-1:0]   tx_airtime_q, tx_airtime_d;
  logic [TAIL_W-1:0]  tail_cnt_q, tail_cnt_d;
  logic               meas_valid_q, meas_valid_d;
  logic               wd_err_q, wd_err_d;

  logic               in_tx;
  logic               in_rf;
  logic               wd_fire;
  logic               enter_tx;
  logic               enter_rf;
  logic               leave_rf;
  logic               enter_guard;
  logic               enter_abort;
  logic [CNT_W-1:0]   air_inc;
  logic [CNT_W-1:0]   wd_inc;
  logic [TAIL_W-1:0]  tail_inc;

  assign in_tx = (state_q == StTxBb) || (state_q == StTxRf);
  assign in_rf = (state_q == StTxRf);

  // wd_q holds the number of TX cycles already completed in this episode
  assign wd_fire = in_tx && (max_tx_top != '0) && (wd_q == (max_tx_top - CNT_W'(1)));

  // Counts including the current TX_RF cycle, saturating at all-ones
  assign air_inc  = (&air_q) ? air_q : air_q + CNT_W'(1);
  assign wd_inc   = (&wd_q) ? wd_q : wd_q + CNT_W'(1);
  assign tail_inc = (in_rf && armed_q && !(&tail_q)) ? tail_q + TAIL_W'(1) : tail_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; rf has priority over bb, watchdog overrides TX transitions
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (tx_rf_is_ongoing) begin
          state_d = StTxRf;
        end else if (tx_bb_is_ongoing) begin
          state_d = StTxBb;
        end
      end
      StTxBb: begin
        if (wd_fire) begin
          state_d = StAbort;
        end else if (tx_rf_is_ongoing) begin
          state_d = StTxRf;
        end else if (!tx_bb_is_ongoing) begin
          state_d = StGuard;
        end
      end
      StTxRf: begin
        if (wd_fire) begin
          state_d = StAbort;
        end else if (!tx_rf_is_ongoing) begin
          state_d = StGuard;
        end
      end
      StGuard: begin
        if (tx_rf_is_ongoing) begin
          state_d = StTxRf;
        end else if (tx_bb_is_ongoing) begin
          state_d = StTxBb;
        end else if (guard_q == '0) begin
          state_d = StIdle;
        end
      end
      StAbort: begin
        if (!tx_bb_is_ongoing && !tx_rf_is_ongoing) begin
          state_d = StGuard;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs decoded from the state register
  always_comb begin
    rx_blank   = 1'b1;
    tx_ant_sel = 1'b0;
    unique case (state_q)
      StIdle:  rx_blank   = 1'b0;
      StTxRf:  tx_ant_sel = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state_q;

  assign enter_tx    = ((state_q == StIdle) || (state_q == StGuard)) &&
                       ((state_d == StTxBb) || (state_d == StTxRf));
  assign enter_rf    = (state_d == StTxRf) && !in_rf;
  assign leave_rf    = in_rf && (state_d != StTxRf);
  assign enter_guard = (state_d == StGuard) && (state_q != StGuard);
  assign enter_abort = (state_d == StAbort) && (state_q != StAbort);

  // Counter and measurement next-state
  always_comb begin
    wd_d         = wd_q;
    air_d        = air_q;
    tail_d       = tail_q;
    armed_d      = armed_q;
    guard_d      = guard_q;
    tx_airtime_d = tx_airtime_q;
    tail_cnt_d   = tail_cnt_q;
    meas_valid_d = 1'b0;
    wd_err_d     = wd_err_q;

    // TX_BB -> TX_RF keeps counting; only a fresh TX episode restarts the watchdog
    if (enter_tx) begin
      wd_d = '0;
    end else if (in_tx) begin
      wd_d = wd_inc;
    end

    if (enter_rf) begin
      air_d   = '0;
      tail_d  = '0;
      armed_d = 1'b0;
    end else if (in_rf) begin
      air_d  = air_inc;
      tail_d = tail_inc;
      if (pulse_tx_bb_end_almost) begin
        armed_d = 1'b1;
      end
    end

    if (leave_rf) begin
      tx_airtime_d = air_inc;
      tail_cnt_d   = tail_inc;
      meas_valid_d = 1'b1;
    end

    if (enter_guard) begin
      guard_d = post_guard_top;
    end else if ((state_q == StGuard) && (guard_q != '0)) begin
      guard_d = guard_q - GUARD_W'(1);
    end

    if (enter_abort) begin
      wd_err_d = 1'b1;
    end else if (wd_err_clr) begin
      wd_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q         <= '0;
      air_q        <= '0;
      tail_q       <= '0;
      armed_q      <= 1'b0;
      guard_q      <= '0;
      tx_airtime_q <= '0;
      tail_cnt_q   <= '0;
      meas_valid_q <= 1'b0;
      wd_err_q     <= 1'b0;
    end else begin
      wd_q         <= wd_d;
      air_q        <= air_d;
      tail_q       <= tail_d;
      armed_q      <= armed_d;
      guard_q      <= guard_d;
      tx_airtime_q <= tx_airtime_d;
      tail_cnt_q   <= tail_cnt_d;
      meas_valid_q <= meas_valid_d;
      wd_err_q     <= wd_err_d;
    end
  end

  assign tx_airtime = tx_airtime_q;
  assign tail_cnt   = tail_cnt_q;
  assign meas_valid = meas_valid_q;
  assign wd_err     = wd_err_q;

endmodule

// File: tb/tb_tx_rx_switch_ctrl.sv
// Bench for tx_rx_switch_ctrl: directed frames plus random frames checked against
// a frame-level arithmetic model of states, measurements and the watchdog.
module tb_tx_rx_switch_ctrl;
  localparam int CNT_W   = 16;
  localparam int TAIL_W  = 12;
  localparam int GUARD_W = 10;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               bb = 1'b0;
  logic               rf = 1'b0;
  logic               pulse = 1'b0;
  logic               clr = 1'b0;
  logic [GUARD_W-1:0] guard_top = '0;
  logic [CNT_W-1:0]   max_top = '0;
  logic               rx_blank;
  logic               tx_ant_sel;
  logic [CNT_W-1:0]   tx_airtime;
  logic [TAIL_W-1:0]  tail_cnt;
  logic               meas_valid;
  logic               wd_err;
  logic [2:0]         state_dbg;

  int   errors = 0;
  int   checks = 0;
  int   air_exp = 0;
  int   tail_exp = 0;
  logic wd_exp = 1'b0;

  tx_rx_switch_ctrl #(
    .CNT_W  (CNT_W),
    .TAIL_W (TAIL_W),
    .GUARD_W(GUARD_W)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .tx_bb_is_ongoing      (bb),
    .tx_rf_is_ongoing      (rf),
    .pulse_tx_bb_end_almost(pulse),
    .post_guard_top        (guard_top),
    .max_tx_top            (max_top),
    .wd_err_clr            (clr),
    .rx_blank              (rx_blank),
    .tx_ant_sel            (tx_ant_sel),
    .tx_airtime            (tx_airtime),
    .tail_cnt              (tail_cnt),
    .meas_valid            (meas_valid),
    .wd_err                (wd_err),
    .state_dbg             (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // st: 0 idle, 1 BB only, 2 RF on air, 3 guard, 4 abort
  task automatic check_all(input string tag, input int st, input bit mv);
    check({tag, ".state"}, 32'(state_dbg), st);
    check({tag, ".blank"}, 32'(rx_blank), (st != 0) ? 1 : 0);
    check({tag, ".ant"}, 32'(tx_ant_sel), (st == 2) ? 1 : 0);
    check({tag, ".meas_valid"}, 32'(meas_valid), 32'(mv));
    check({tag, ".airtime"}, 32'(tx_airtime), air_exp);
    check({tag, ".tail"}, 32'(tail_cnt), tail_exp);
    check({tag, ".wd_err"}, 32'(wd_err), 32'(wd_exp));
  endtask

  // Frame: l BB-only samples, then r samples with rf=1; optional end-almost pulse
  // at rf offset p (1..r); guard g; watchdog limit m. Edge k is the k-th sample.
  task automatic run_frame(input string tag, input int l, input int r, input bit pen,
                           input int p, input int g, input int m, input bit rnd_clr);
    int  e;
    int  rel;
    int  st;
    bit  abort;
    bit  mv;
    bit  dbl;
    abort = (m != 0) && (m <= l + r);
    e     = abort ? m : l + r;
    rel   = abort ? ((l + r > m + 1) ? l + r : m + 1) : e;
    dbl   = 1'($urandom_range(0, 1));
    guard_top = g[GUARD_W-1:0];
    max_top   = m[CNT_W-1:0];
    for (int k = 0; k <= rel + g + 2; k++) begin
      rf    = (k >= l) && (k < l + r);
      bb    = (k < l + r) && !(pen && k >= l + p);
      pulse = pen && ((k == l + p) || (dbl && k == l + p + 2));
      clr   = rnd_clr && ($urandom_range(0, 3) == 0);
      step();
      if (k < e) st = (k >= l) ? 2 : 1;
      else if (k < rel) st = 4;
      else if (k <= rel + g) st = 3;
      else st = 0;
      mv = (k == e) && (e > l);
      if (mv) begin
        air_exp  = e - l;
        tail_exp = (pen && (l + p <= e)) ? e - l - p : 0;
        if (tail_exp > (1 << TAIL_W) - 1) tail_exp = (1 << TAIL_W) - 1;
      end
      if (abort && k == e) wd_exp = 1'b1;
      else if (clr) wd_exp = 1'b0;
      check_all(tag, st, mv);
    end
    bb    = 1'b0;
    rf    = 1'b0;
    pulse = 1'b0;
    clr   = 1'b1;
    step();
    wd_exp = 1'b0;
    check_all({tag, ".clr"}, 0, 1'b0);
    clr = 1'b0;
  endtask

  initial begin
    int st;
    bit mv;
    int l;
    int r;
    int p;
    int g;
    int m;
    int mode;
    bit pen;

    rst = 1'b1;
    step();
    step();
    check_all("reset", 0, 1'b0);
    rst = 1'b0;
    step();
    check_all("post_reset", 0, 1'b0);

    run_frame("normal", 10, 100, 1'b1, 90, 5, 0, 1'b0);
    run_frame("zero_guard", 10, 100, 1'b1, 90, 0, 0, 1'b0);
    run_frame("watchdog", 0, 80, 1'b0, 0, 5, 50, 1'b0);
    run_frame("bb_only", 20, 0, 1'b0, 0, 5, 0, 1'b0);
    run_frame("wd_bb_abort", 12, 10, 1'b0, 0, 2, 6, 1'b1);
    run_frame("wd_clr_race", 0, 30, 1'b1, 5, 3, 10, 1'b1);
    run_frame("tail_sat", 2, 4200, 1'b1, 1, 2, 0, 1'b0);

    // Second frame arrives during the guard of the first; rx_blank must not drop
    guard_top = 10'd20;
    max_top   = '0;
    for (int k = 0; k <= 170; k++) begin
      rf    = ((k >= 10) && (k < 110)) || ((k >= 115) && (k < 145));
      bb    = (k < 100);
      pulse = (k == 100);
      clr   = 1'b0;
      step();
      if (k < 10) st = 1;
      else if (k < 110) st = 2;
      else if (k < 115) st = 3;
      else if (k < 145) st = 2;
      else if (k <= 165) st = 3;
      else st = 0;
      mv = (k == 110) || (k == 145);
      if (k == 110) begin
        air_exp  = 100;
        tail_exp = 10;
      end
      if (k == 145) begin
        air_exp  = 30;
        tail_exp = 0;
      end
      check_all("b2b", st, mv);
    end

    for (int i = 0; i < 40; i++) begin
      l    = int'($urandom_range(0, 8));
      r    = int'($urandom_range((l == 0) ? 1 : 0, 50));
      pen  = (r > 0) && ($urandom_range(0, 2) != 0);
      p    = pen ? int'($urandom_range(1, r)) : 0;
      g    = int'($urandom_range(0, 12));
      mode = int'($urandom_range(0, 3));
      if (mode < 2) m = 0;
      else if (mode == 2) m = int'($urandom_range(1, l + r));
      else m = l + r + int'($urandom_range(1, 20));
      run_frame("rand", l, r, pen, p, g, m, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an RF burst
    guard_top = 10'd5;
    max_top   = '0;
    for (int k = 0; k < 60; k++) begin
      rf    = (k >= 10);
      bb    = 1'b1;
      pulse = 1'b0;
      step();
    end
    rst   = 1'b1;
    bb    = 1'b0;
    rf    = 1'b0;
    step();
    air_exp  = 0;
    tail_exp = 0;
    wd_exp   = 1'b0;
    check_all("rst_mid", 0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      check_all("after_rst", 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_rx_switch_ctrl.md
Name: tx_rx_switch_ctrl

Overview:
Consumes the TX-activity indications of the TX-on detector (tx_bb_is_ongoing, tx_rf_is_ongoing, pulse_tx_bb_end_almost). It drives the RF T/R antenna-switch select and the receiver blanking gate, and holds a programmable post-TX guard. It also measures per-frame RF airtime and the BB-end to RF-end tail, and aborts runaway transmissions with a watchdog. It sits between the TX-on detector and the RF front-end/RX gating in xpu.

Parameters:
CNT_W, 16, width of airtime and watchdog counters
TAIL_W, 12, width of the BB-end to RF-end tail counter
GUARD_W, 10, width of the post-TX guard counter

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
tx_bb_is_ongoing  in  1  BB transmit active
tx_rf_is_ongoing  in  1  RF transmit active (delayed version of BB)
pulse_tx_bb_end_almost  in  1  one-cycle pulse at BB end
post_guard_top  in  GUARD_W  extra RX-blank cycles after RF end
max_tx_top  in  CNT_W  watchdog limit in cycles; 0 = disabled
wd_err_clr  in  1  clears wd_err
rx_blank  out  1  1 = receiver gated off
tx_ant_sel  out  1  1 = antenna switch on TX path
tx_airtime  out  CNT_W  cycles spent in TX_RF, last frame
tail_cnt  out  TAIL_W  TX_RF cycles after the end-almost pulse, last frame
meas_valid  out  1  one-cycle pulse when tx_airtime/tail_cnt update
wd_err  out  1  sticky watchdog abort flag
state_dbg  out  3  current FSM state encoding

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous, active-high.
- Reset values: all outputs 0. State is IDLE. All counters are 0.
- Timing: Moore FSM. rx_blank, tx_ant_sel and state_dbg decode from the state register. An input sampled at edge N affects outputs from cycle N+1.
- Encodings: IDLE=0, TX_BB=1, TX_RF=2, GUARD=3, ABORT=4.
- IDLE (blank=0, ant=0):
  - rf=1 → TX_RF.
  - else bb=1 → TX_BB.
- TX_BB (blank=1, ant=0):
  - rf=1 → TX_RF.
  - else bb=0 → GUARD. This is a BB abort with no RF; no measurement and no meas_valid.
- TX_RF (blank=1, ant=1):
  - airtime counter clears on entry, then increments once per TX_RF cycle, saturating at all-ones.
  - tail counter clears on entry. A pulse_tx_bb_end_almost sampled in TX_RF arms it. Each later TX_RF cycle increments it, saturating. A second pulse does not restart it.
  - rf=0 → GUARD. tx_airtime and tail_cnt latch, and meas_valid=1 in the first GUARD cycle. tail_cnt=0 if the pulse never arrived.
- GUARD (blank=1, ant=0):
  - guard counter loads post_guard_top on entry and decrements each cycle.
  - Duration is post_guard_top+1 cycles, then IDLE.
  - rf=1 in any GUARD cycle → TX_RF; else bb=1 → TX_BB. This handles back-to-back frames such as SIFS/ACK, and rx_blank stays 1 throughout.
- Watchdog:
  - wd counter clears on entry from IDLE or GUARD into TX_BB/TX_RF.
  - It counts every TX_BB or TX_RF cycle, continuously across the TX_BB→TX_RF transition.
  - If max_tx_top!=0, the state is TX_BB/TX_RF and wd==max_tx_top-1, the next state is ABORT instead of the normal transition. Total TX residence is therefore exactly max_tx_top cycles.
  - On entry to ABORT: wd_err←1. If coming from TX_RF, measurements latch with meas_valid=1.
- ABORT (blank=1, ant=0): stays until bb=0 and rf=0 in the same sample, then → GUARD. No meas_valid on that GUARD entry.
- wd_err: sticky. wd_err_clr clears it; a set in the same cycle wins.
- Priority: rf over bb in all transitions. Watchdog overrides all TX transitions.
- max_tx_top and post_guard_top are sampled when used (watchdog compare, guard load); they are not shadowed.
- Reset mid-frame: immediate return to reset values next cycle; no meas_valid.

Test Plan:
1. Normal frame. post_guard_top=5, max_tx_top=0; bb=1 from cycle 10, rf=1 cycles 20..119, bb=0 and end-almost pulse at 110.
   - rx_blank=1 cycles 11..126; tx_ant_sel=1 cycles 21..120.
   - meas_valid at 121 with tx_airtime=100, tail_cnt=10.
   - IDLE and rx_blank=0 at 127.
2. Zero guard. post_guard_top=0, same frame → GUARD only cycle 121, rx_blank=0 at 122.
3. Back-to-back. post_guard_top=20; second rf=1 for 30 cycles, sampled at cycle 125 (GUARD).
   - rx_blank never drops; ant=1 126..155.
   - second meas_valid at 156 with airtime=30, tail_cnt=0.
4. Watchdog. max_tx_top=50; bb=rf=1 from cycle 0, released at 80.
   - TX_RF 1..50, ABORT at 51: ant=0, wd_err=1, meas_valid with airtime=50.
   - GUARD from 81.
   - wd_err_clr at 200 → wd_err=0 at 201.
5. BB without RF. bb=1 cycles 10..29, rf=0 → TX_BB 11..30, GUARD at 31, no meas_valid, ant stays 0.
6. Reset mid-frame. rst=1 at cycle 60 of test 1 → cycle 61: all outputs 0, state_dbg=0, no meas_valid afterward.
